// File: rtl/prio_pkg.sv
// Shared definitions for the priority decode/pulse slice: default index width,
// FSM state encoding and a ceil(log2) helper for sizing counters.
package prio_pkg;

    localparam int QW_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // ceil(log2(x)); returns 0 for x <= 1
    function automatic int clog2(input int x);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < x) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_dec_2to4_pulse_timer.sv
// Loadable down-counter shared by the DRIVE and GAP phases. Load wins over
// decrement; the count parks at zero and zero is flagged combinationally.
module pulse_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    assign zero = (cnt == '0);

    // load, or count down toward zero while enabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (en && !zero) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/prio_dec_2to4_pulse.sv
// Accepts an encoded index with valid, drives the matching one-hot line for
// PULSE_LEN cycles, then holds off for GAP_LEN idle cycles before the next
// code can be taken. Codes presented while busy are dropped, not queued.
module prio_dec_2to4_pulse
    import prio_pkg::*;
#(
    parameter  int QW        = QW_DEF,
    parameter  int PULSE_LEN = 3,
    parameter  int GAP_LEN   = 1,
    localparam int N         = 1 << QW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [QW-1:0] q,
    input  logic          v,
    output logic          ready,
    output logic [N-1:0]  y,
    output logic          busy,
    output logic          done
);

    localparam int PG_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CMAX   = (PG_MAX > 2) ? PG_MAX : 2;
    localparam int CW     = clog2(CMAX);

    localparam logic [CW-1:0] PL_M1 = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] GL_M1 = CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          zero;
    logic          ld;
    logic [CW-1:0] ld_val;
    logic          en;

    assign ready = (state == IDLE);

    // timer loads on accept (pulse length) and at end of pulse (gap length)
    always_comb begin
        ld     = 1'b0;
        ld_val = PL_M1;
        en     = (state != IDLE);
        if (state == IDLE && v) begin
            ld     = 1'b1;
            ld_val = PL_M1;
        end else if (state == DRIVE && zero && GAP_LEN > 0) begin
            ld     = 1'b1;
            ld_val = GL_M1;
        end
    end

    pulse_timer #(.W(CW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld     (ld),
        .ld_val (ld_val),
        .en     (en),
        .cnt    (cnt),
        .zero   (zero)
    );

    // phase sequencing and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            y     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (v) begin
                        state <= DRIVE;
                        y     <= N'(1) << q;
                        busy  <= 1'b1;
                        done  <= (PULSE_LEN == 1);
                    end
                end
                DRIVE: begin
                    if (!zero) begin
                        done <= (cnt == CW'(1));
                    end else begin
                        y    <= '0;
                        done <= 1'b0;
                        if (GAP_LEN > 0) begin
                            state <= GAP;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (zero) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    y     <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_dec_2to4_pulse.sv
// Bench for prio_dec_2to4_pulse: default configuration (3/1) alongside the
// boundary configuration (1/0), both fed identical stimulus. Reference model
// tracks cycles elapsed since the last accept and derives outputs from that.
module tb_prio_dec_2to4_pulse;

    localparam int BIG = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v = 1'b0;
    logic [1:0] q = 2'd0;

    logic       rdy_a, busy_a, done_a;
    logic [3:0] y_a;
    logic       rdy_b, busy_b, done_b;
    logic [3:0] y_b;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int idx    = 0;

    int since [2] = '{BIG, BIG};
    int code  [2] = '{0, 0};
    int pl    [2] = '{3, 1};
    int gl    [2] = '{1, 0};

    always #5 clk = ~clk;

    prio_dec_2to4_pulse #(.QW(2), .PULSE_LEN(3), .GAP_LEN(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (q),
        .v     (v),
        .ready (rdy_a),
        .y     (y_a),
        .busy  (busy_a),
        .done  (done_a)
    );

    prio_dec_2to4_pulse #(.QW(2), .PULSE_LEN(1), .GAP_LEN(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (q),
        .v     (v),
        .ready (rdy_b),
        .y     (y_b),
        .busy  (busy_b),
        .done  (done_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    endtask

    // outputs as a function of edges elapsed since the accepting edge
    function automatic int m_y(input int i);
        return (since[i] < pl[i]) ? (1 << code[i]) : 0;
    endfunction
    function automatic int m_done(input int i);
        return (since[i] == pl[i] - 1) ? 1 : 0;
    endfunction
    function automatic int m_busy(input int i);
        return (since[i] < pl[i] + gl[i]) ? 1 : 0;
    endfunction
    function automatic int m_rdy(input int i);
        return (since[i] >= pl[i] + gl[i]) ? 1 : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) since[i] = BIG;
            else if (m_rdy(i) == 1 && v) begin
                since[i] = 0;
                code[i]  = int'(q);
            end else if (since[i] < BIG) since[i]++;
        end
        cyc++;
        #1;
        chk("y_a",    int'(y_a),    m_y(0));
        chk("done_a", int'(done_a), m_done(0));
        chk("busy_a", int'(busy_a), m_busy(0));
        chk("rdy_a",  int'(rdy_a),  m_rdy(0));
        chk("y_b",    int'(y_b),    m_y(1));
        chk("done_b", int'(done_b), m_done(1));
        chk("busy_b", int'(busy_b), m_busy(1));
        chk("rdy_b",  int'(rdy_b),  m_rdy(1));
    endtask

    initial begin
        // reset held two edges with a live code on the inputs
        rst_n = 1'b0; v = 1'b1; q = 2'd3;
        step(); step();
        rst_n = 1'b1; v = 1'b0;
        repeat (3) step();

        // single accept of q=2
        q = 2'd2; v = 1'b1;
        step();
        v = 1'b0; q = 2'd0;
        repeat (6) step();

        // v held high, q advancing to the next code after each accept
        idx = 0; q = 2'd0; v = 1'b1;
        repeat (22) begin
            step();
            if (since[0] == 0) begin
                idx++;
                q = 2'(idx);
            end
        end
        v = 1'b0;
        repeat (6) step();

        // new code while busy must be ignored until the next idle edge
        q = 2'd1; v = 1'b1;
        step();
        q = 2'd3;
        repeat (8) step();
        v = 1'b0;
        repeat (3) step();

        // abort a pulse with reset during its second drive cycle
        q = 2'd0; v = 1'b1;
        step();
        v = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("abort_y_a", int'(y_a), 0);
        chk("abort_done_a", int'(done_a), 0);
        rst_n = 1'b1;
        repeat (4) step();

        // randomized traffic with occasional resets
        repeat (400) begin
            rst_n = ($urandom_range(0, 39) != 0);
            v     = ($urandom_range(0, 3) != 0);
            q     = 2'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
